// File: rtl/vxc_result_writer.sv
// Result write-back stage: buffers 8-lane result rows in a small FIFO and writes them to result memory.
// Optional macro VXC_WB_ZERO_PAD_EN zeroes the unused lanes of the last row of a cluster.
module vxc_result_writer #(
   parameter int element_width                   = 32,
   parameter int no_of_units                     = 8,
   parameter int number_of_equations_per_cluster = 16,
   parameter int ADDR_WIDTH                      = 8,
   parameter int BASE_ADDR                       = 0,
   parameter int FIFO_DEPTH                      = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [element_width*no_of_units-1:0] vXc_add_8_output,
   input  logic                                 result_mem_we,
   input  logic                                 mem_ready,
   output logic                                 mem_we,
   output logic [ADDR_WIDTH-1:0]                mem_addr,
   output logic [element_width*no_of_units-1:0] mem_wdata,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 overflow
);
   localparam int ROW_W = element_width * no_of_units;
   localparam int ROWS  = (number_of_equations_per_cluster + no_of_units - 1) / no_of_units;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int CNT_W = $clog2(ROWS + 1);
   localparam logic [CNT_W-1:0] ROWS_C = CNT_W'(ROWS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic [ROW_W-1:0]     fifo_r [FIFO_DEPTH];
   logic [PTR_W-1:0]     rd_ptr_r, wr_ptr_r, head_s;
   logic [OCC_W-1:0]     occ_r, occ_pop_s;
   logic [CNT_W-1:0]     captured_r, written_r, captured_s, written_s;
   logic                 init_s, push_s, pop_s, ovf_s, full_s, we_s, ovf_next_s;
   logic [ADDR_WIDTH-1:0] addr_s;
   logic [ROW_W-1:0]     wdata_s;

`ifdef VXC_WB_ZERO_PAD_EN
   localparam int LAST_VALID = number_of_equations_per_cluster - (ROWS - 1) * no_of_units;

   function automatic logic [ROW_W-1:0] pad_row(input logic [ROW_W-1:0] row, input logic [CNT_W-1:0] idx);
      logic [ROW_W-1:0] res;
      res = row;
      if (idx == CNT_W'(ROWS - 1)) begin
         for (int l = 0; l < no_of_units; l++) begin
            if (l >= LAST_VALID) begin
               res[l*element_width +: element_width] = {element_width{1'b0}};
            end else begin
               res[l*element_width +: element_width] = row[l*element_width +: element_width];
            end
         end
      end else begin
         res = row;
      end
      return res;
   endfunction
`endif

   // Capture/write decisions, next state and next registered outputs.
   always_comb begin
      init_s  = 1'b0;
      push_s  = 1'b0;
      ovf_s   = 1'b0;
      state_s = state_r;
      pop_s   = mem_we & mem_ready;
      full_s  = (occ_r == OCC_W'(FIFO_DEPTH));
      // A full FIFO still accepts a row when the head leaves on the same edge.
      if ((state_r == ST_RUN) && result_mem_we) begin
         if (!full_s || pop_s) begin
            push_s = 1'b1;
         end else begin
            ovf_s = 1'b1;
         end
      end else begin
         push_s = 1'b0;
      end
      captured_s = captured_r + CNT_W'(push_s);
      written_s  = written_r + CNT_W'(pop_s);
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               init_s  = 1'b1;
               state_s = ST_RUN;
            end else begin
               state_s = state_r;
            end
         end
         ST_RUN: begin
            if (captured_s == ROWS_C) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (written_s == ROWS_C) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: state_s = ST_IDLE;
      endcase
      if (init_s) begin
         captured_s = {CNT_W{1'b0}};
         written_s  = {CNT_W{1'b0}};
      end else begin
         captured_s = captured_s;
         written_s  = written_s;
      end
      // The output stage sees the FIFO as it stands after this edge's pop, ignoring this edge's push.
      occ_pop_s = occ_r - OCC_W'(pop_s);
      head_s    = rd_ptr_r + PTR_W'(pop_s);
      we_s      = (occ_pop_s != {OCC_W{1'b0}}) && ((state_s == ST_RUN) || (state_s == ST_DRAIN));
      if (we_s) begin
`ifdef VXC_WB_ZERO_PAD_EN
         wdata_s = pad_row(fifo_r[head_s], written_s);
`else
         wdata_s = fifo_r[head_s];
`endif
      end else begin
         wdata_s = mem_wdata;
      end
      addr_s     = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(written_s);
      ovf_next_s = init_s ? 1'b0 : (overflow | ovf_s);
   end

   // State, FIFO pointers, row counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         rd_ptr_r   <= {PTR_W{1'b0}};
         wr_ptr_r   <= {PTR_W{1'b0}};
         occ_r      <= {OCC_W{1'b0}};
         captured_r <= {CNT_W{1'b0}};
         written_r  <= {CNT_W{1'b0}};
         mem_we     <= 1'b0;
         mem_addr   <= ADDR_WIDTH'(BASE_ADDR);
         mem_wdata  <= {ROW_W{1'b0}};
         busy       <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state_r <= state_s;
         if (init_s) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
         end else begin
            rd_ptr_r <= head_s;
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_s);
            occ_r    <= occ_r + OCC_W'(push_s) - OCC_W'(pop_s);
         end
         captured_r <= captured_s;
         written_r  <= written_s;
         mem_we     <= we_s;
         mem_addr   <= addr_s;
         mem_wdata  <= wdata_s;
         busy       <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
         done       <= (state_s == ST_DONE);
         overflow   <= ovf_next_s;
      end
   end

   // Row storage; contents are only meaningful while occupied, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_r[wr_ptr_r] <= vXc_add_8_output;
      end
   end
endmodule
